// File: rtl/fpu_top_level.sv
// Three-stage binary32 add/sub/mul unit with RISC-V rounding modes and fflags.
// Stage 1 captures operands, stage 2 aligns or multiplies, stage 3 normalizes and rounds.
module fpu_top_level (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] floating_point1,
  input  logic [31:0] floating_point2,
  input  logic [2:0]  frm,
  input  logic [6:0]  funct7,
  output logic [31:0] floating_point_out,
  output logic [4:0]  flags
);

  localparam logic [6:0] OP_ADD = 7'b0000000;
  localparam logic [6:0] OP_SUB = 7'b0000100;
  localparam logic [6:0] OP_MUL = 7'b0001000;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------- stage 1: operand capture ----------------
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  frm_q, frm_d;
  logic [6:0]  op_q, op_d;

  always_comb begin
    a_d   = floating_point1;
    b_d   = floating_point2;
    frm_d = (frm > RM_RMM) ? RM_RNE : frm;
    op_d  = funct7;
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      frm_q <= 3'd0;
      op_q  <= 7'd0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      frm_q <= frm_d;
      op_q  <= op_d;
    end
  end

  // ---------------- stage 2: unpack, align / multiply ----------------
  logic        sa, sb, sb_add;
  logic [7:0]  ea, eb, ea_e, eb_e;
  logic [22:0] fa, fb;
  logic [23:0] ma, mb;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic        is_add, is_sub, is_mul, op_valid;

  always_comb begin
    sa = a_q[31];
    ea = a_q[30:23];
    fa = a_q[22:0];
    sb = b_q[31];
    eb = b_q[30:23];
    fb = b_q[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_snan = a_nan && !fa[22];
    b_snan = b_nan && !fb[22];
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    // exponent 0 covers both true zeros and flushed subnormals
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    ea_e   = a_zero ? 8'd0 : ea;
    eb_e   = b_zero ? 8'd0 : eb;
    ma     = a_zero ? 24'd0 : {1'b1, fa};
    mb     = b_zero ? 24'd0 : {1'b1, fb};
    is_add   = (op_q == OP_ADD);
    is_sub   = (op_q == OP_SUB);
    is_mul   = (op_q == OP_MUL);
    op_valid = is_add || is_sub || is_mul;
    sb_add   = sb ^ is_sub;
  end

  logic        swap, big_s, sml_s, eff_sub, add_s;
  logic [7:0]  big_e, sml_e, diff_e;
  logic [23:0] big_m, sml_m;
  logic [4:0]  sh;
  logic [53:0] wide;
  logic [26:0] aligned;
  logic [27:0] sum;

  always_comb begin
    swap   = {eb_e, mb} > {ea_e, ma};
    big_s  = swap ? sb_add : sa;
    sml_s  = swap ? sa : sb_add;
    big_e  = swap ? eb_e : ea_e;
    sml_e  = swap ? ea_e : eb_e;
    big_m  = swap ? mb : ma;
    sml_m  = swap ? ma : mb;
    diff_e = big_e - sml_e;
    sh     = (diff_e > 8'd27) ? 5'd27 : diff_e[4:0];
    wide   = {sml_m, 30'd0} >> sh;
    // everything shifted past the round bit collapses into the sticky LSB
    aligned = {wide[53:28], wide[27] | (|wide[26:0])};
    eff_sub = big_s ^ sml_s;
    if (eff_sub)
      sum = {1'b0, big_m, 3'b000} - {1'b0, aligned};
    else
      sum = {1'b0, big_m, 3'b000} + {1'b0, aligned};
    if (sum == 28'd0)
      add_s = eff_sub ? (frm_q == RM_RDN) : big_s;
    else
      add_s = big_s;
  end

  logic [47:0]       prod;
  logic              mul_s;
  logic signed [9:0] mul_e;

  always_comb begin
    prod  = {24'd0, ma} * {24'd0, mb};
    mul_s = sa ^ sb;
    mul_e = $signed({2'b00, ea_e}) + $signed({2'b00, eb_e}) - 10'sd127;
  end

  // Stage-2 word: value = m2 * 2^(e2 - 127 - 26), hidden bit normally at m2[26]
  logic              s2_q, s2_d;
  logic signed [9:0] e2_q, e2_d;
  logic [27:0]       m2_q, m2_d;
  logic [2:0]        frm2_q, frm2_d;
  logic              spec2_q, spec2_d;
  logic [31:0]       sval2_q, sval2_d;
  logic [4:0]        sflg2_q, sflg2_d;

  always_comb begin
    frm2_d  = frm_q;
    spec2_d = 1'b0;
    sval2_d = 32'd0;
    sflg2_d = 5'd0;
    if (is_mul) begin
      s2_d = mul_s;
      e2_d = mul_e;
      m2_d = {prod[47:21], |prod[20:0]};
    end else begin
      s2_d = add_s;
      e2_d = $signed({2'b00, big_e});
      m2_d = sum;
    end
    if (!op_valid) begin
      spec2_d = 1'b1;
    end else if (a_nan || b_nan) begin
      spec2_d = 1'b1;
      sval2_d = QNAN;
      sflg2_d = {a_snan || b_snan, 4'b0000};
    end else if (is_mul) begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) begin
        spec2_d = 1'b1;
        sval2_d = QNAN;
        sflg2_d = 5'b10000;
      end else if (a_inf || b_inf) begin
        spec2_d = 1'b1;
        sval2_d = {mul_s, 8'hFF, 23'd0};
      end
    end else begin
      if (a_inf && b_inf && (sa != sb_add)) begin
        spec2_d = 1'b1;
        sval2_d = QNAN;
        sflg2_d = 5'b10000;
      end else if (a_inf) begin
        spec2_d = 1'b1;
        sval2_d = {sa, 8'hFF, 23'd0};
      end else if (b_inf) begin
        spec2_d = 1'b1;
        sval2_d = {sb_add, 8'hFF, 23'd0};
      end
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      s2_q    <= 1'b0;
      e2_q    <= 10'sd0;
      m2_q    <= 28'd0;
      frm2_q  <= 3'd0;
      spec2_q <= 1'b0;
      sval2_q <= 32'd0;
      sflg2_q <= 5'd0;
    end else begin
      s2_q    <= s2_d;
      e2_q    <= e2_d;
      m2_q    <= m2_d;
      frm2_q  <= frm2_d;
      spec2_q <= spec2_d;
      sval2_q <= sval2_d;
      sflg2_q <= sflg2_d;
    end
  end

  // ---------------- stage 3: normalize, round, pack ----------------
  logic [4:0]        lz;
  logic              found;
  logic [26:0]       norm;
  logic signed [9:0] e_n, e_r;
  logic              g, rs, inexact, inc, ovf_inf;
  logic [24:0]       mant_r;
  logic [22:0]       frac_r;
  logic [31:0]       out_q, out_d;
  logic [4:0]        flags_q, flags_d;

  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && m2_q[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    if (m2_q[27]) begin
      norm = {m2_q[27:2], m2_q[1] | m2_q[0]};
      e_n  = e2_q + 10'sd1;
    end else begin
      norm = m2_q[26:0] << lz;
      e_n  = e2_q - $signed({5'd0, lz});
    end
    g       = norm[2];
    rs      = norm[1] | norm[0];
    inexact = g | rs;
    case (frm2_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_q & inexact;
      RM_RUP:  inc = ~s2_q & inexact;
      RM_RMM:  inc = g;
      default: inc = g & (rs | norm[3]);
    endcase
    mant_r = {1'b0, norm[26:3]} + {24'd0, inc};
    if (mant_r[24]) begin
      e_r    = e_n + 10'sd1;
      frac_r = mant_r[23:1];
    end else begin
      e_r    = e_n;
      frac_r = mant_r[22:0];
    end
    ovf_inf = (frm2_q == RM_RNE) || (frm2_q == RM_RMM) ||
              ((frm2_q == RM_RDN) && s2_q) || ((frm2_q == RM_RUP) && !s2_q);

    out_d   = {s2_q, e_r[7:0], frac_r};
    flags_d = {4'b0000, inexact};
    if (spec2_q) begin
      out_d   = sval2_q;
      flags_d = sflg2_q;
    end else if (m2_q == 28'd0) begin
      out_d   = {s2_q, 31'd0};
      flags_d = 5'd0;
    end else if (e_n < 10'sd1) begin
      out_d   = {s2_q, 31'd0};
      flags_d = 5'b00011;
    end else if (e_r >= 10'sd255) begin
      out_d   = ovf_inf ? {s2_q, 8'hFF, 23'd0} : {s2_q, 31'h7F7F_FFFF};
      flags_d = 5'b00101;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      out_q   <= 32'd0;
      flags_q <= 5'd0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign floating_point_out = out_q;
  assign flags              = flags_q;

endmodule

// File: tb/tb_fpu_top_level.sv
// Directed-vector bench for fpu_top_level: table of hand-computed results plus
// pipelining and mid-stream reset sequences.
module tb_fpu_top_level;

  logic        clk;
  logic        nrst;
  logic [31:0] floating_point1;
  logic [31:0] floating_point2;
  logic [2:0]  frm;
  logic [6:0]  funct7;
  logic [31:0] floating_point_out;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  fpu_top_level dut (
    .clk                (clk),
    .nrst               (nrst),
    .floating_point1    (floating_point1),
    .floating_point2    (floating_point2),
    .frm                (frm),
    .funct7             (funct7),
    .floating_point_out (floating_point_out),
    .flags              (flags)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] ADD = 7'b0000000;
  localparam logic [6:0] SUB = 7'b0000100;
  localparam logic [6:0] MUL = 7'b0001000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [6:0]  op;
    logic [31:0] exp_out;
    logic [4:0]  exp_flg;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [6:0] op);
    floating_point1 = a;
    floating_point2 = b;
    frm             = rm;
    funct7          = op;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_pair(input string name, input logic [31:0] exp_out, input logic [4:0] exp_flg);
    chk({name, "_out"}, floating_point_out, exp_out);
    chk({name, "_flags"}, {27'd0, flags}, {27'd0, exp_flg});
  endtask

  initial begin
    vecs.push_back('{32'h3F800000, 32'h3F800000, 3'b000, ADD, 32'h40000000, 5'b00000});
    vecs.push_back('{32'h40400000, 32'h3F800000, 3'b000, SUB, 32'h40000000, 5'b00000});
    vecs.push_back('{32'h40000000, 32'h40400000, 3'b000, MUL, 32'h40C00000, 5'b00000});
    vecs.push_back('{32'h3F800000, 32'h33800000, 3'b000, ADD, 32'h3F800000, 5'b00001});
    vecs.push_back('{32'h3F800000, 32'h33800000, 3'b011, ADD, 32'h3F800001, 5'b00001});
    vecs.push_back('{32'h3F800000, 32'h33800000, 3'b100, ADD, 32'h3F800001, 5'b00001});
    vecs.push_back('{32'h3F800001, 32'h33800000, 3'b000, ADD, 32'h3F800002, 5'b00001});
    vecs.push_back('{32'h3F800001, 32'h33800000, 3'b001, ADD, 32'h3F800001, 5'b00001});
    vecs.push_back('{32'h3F800001, 32'h33800000, 3'b101, ADD, 32'h3F800002, 5'b00001});
    vecs.push_back('{32'hBF800000, 32'hB3800000, 3'b010, ADD, 32'hBF800001, 5'b00001});
    vecs.push_back('{32'hBF800000, 32'hB3800000, 3'b011, ADD, 32'hBF800000, 5'b00001});
    vecs.push_back('{32'h3F800000, 32'h00800000, 3'b000, ADD, 32'h3F800000, 5'b00001});
    vecs.push_back('{32'h3F800000, 32'h00800000, 3'b011, ADD, 32'h3F800001, 5'b00001});
    vecs.push_back('{32'h3F800001, 32'h3F800000, 3'b000, SUB, 32'h34000000, 5'b00000});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'b000, MUL, 32'h3F800002, 5'b00001});
    vecs.push_back('{32'h7F000000, 32'h40000000, 3'b000, MUL, 32'h7F800000, 5'b00101});
    vecs.push_back('{32'h7F000000, 32'h40000000, 3'b001, MUL, 32'h7F7FFFFF, 5'b00101});
    vecs.push_back('{32'h7F000000, 32'h40000000, 3'b010, MUL, 32'h7F7FFFFF, 5'b00101});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, ADD, 32'h7F800000, 5'b00101});
    vecs.push_back('{32'h00800000, 32'h3F000000, 3'b000, MUL, 32'h00000000, 5'b00011});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 3'b000, SUB, 32'h7FC00000, 5'b10000});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 3'b000, SUB, 32'h00000000, 5'b00000});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 3'b010, SUB, 32'h80000000, 5'b00000});
    vecs.push_back('{32'h80000000, 32'h80000000, 3'b000, ADD, 32'h80000000, 5'b00000});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 3'b000, ADD, 32'h7FC00000, 5'b00000});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 3'b000, MUL, 32'h7FC00000, 5'b10000});
    vecs.push_back('{32'h00000000, 32'h7F800000, 3'b000, MUL, 32'h7FC00000, 5'b10000});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 3'b000, ADD, 32'h7F800000, 5'b00000});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 3'b000, MUL, 32'hFF800000, 5'b00000});
    vecs.push_back('{32'h00000001, 32'h00000000, 3'b000, ADD, 32'h00000000, 5'b00000});
    vecs.push_back('{32'h00400000, 32'h40000000, 3'b000, MUL, 32'h00000000, 5'b00000});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 3'b000, 7'b0000001, 32'h00000000, 5'b00000});

    // reset state
    nrst = 1'b1;
    drive(32'h3F800000, 32'h3F800000, 3'b000, ADD);
    #1;
    chk_pair("reset", 32'h00000000, 5'b00000);
    repeat (2) @(posedge clk);
    chk_pair("reset_clocked", 32'h00000000, 5'b00000);
    @(negedge clk);
    nrst = 1'b0;

    // table: hold each vector for three edges, sample on the falling edge
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].op);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_pair($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_flg);
    end

    // back-to-back issue: one new operation every cycle
    @(negedge clk);
    drive(32'h3F800000, 32'h3F800000, 3'b000, ADD);
    @(negedge clk);
    drive(32'h40000000, 32'h40400000, 3'b000, MUL);
    @(negedge clk);
    drive(32'h40400000, 32'h3F800000, 3'b000, SUB);
    @(negedge clk);
    chk_pair("pipe0", 32'h40000000, 5'b00000);
    @(negedge clk);
    chk_pair("pipe1", 32'h40C00000, 5'b00000);
    drive(32'h40000000, 32'h40400000, 3'b000, MUL);
    @(negedge clk);
    chk_pair("pipe2", 32'h40000000, 5'b00000);

    // mid-stream reset clears outputs immediately and refills after three edges
    repeat (3) @(negedge clk);
    chk_pair("pre_reset", 32'h40C00000, 5'b00000);
    nrst = 1'b1;
    #1;
    chk_pair("async_reset", 32'h00000000, 5'b00000);
    repeat (2) @(negedge clk);
    chk_pair("reset_held", 32'h00000000, 5'b00000);
    drive(32'h3F800000, 32'h3F800000, 3'b000, ADD);
    nrst = 1'b0;
    @(negedge clk);
    chk_pair("post_reset_e1", 32'h00000000, 5'b00000);
    @(negedge clk);
    chk_pair("post_reset_e2", 32'h00000000, 5'b00000);
    @(negedge clk);
    chk_pair("post_reset_e3", 32'h40000000, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_top_level.md
# fpu_top_level

Single-precision (IEEE-754 binary32) floating-point arithmetic unit performing add, subtract and multiply with RISC-V rounding modes and RISC-V `fflags`-style exception flags. It is a fully pipelined, three-stage datapath inside the core's FP execution path. It accepts one operation per clock and produces a registered result and flags.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `nrst`  in  1  reset; asynchronous, active-high (asserted = 1). Clears all pipeline and output registers.
- `floating_point1`  in  32  operand A (binary32).
- `floating_point2`  in  32  operand B (binary32).
- `frm`  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE.
- `funct7`  in  7  operation: 7'b0000000 add (A+B), 7'b0000100 sub (A−B), 7'b0001000 mul (A×B). Any other code gives result 0x00000000 and flags 0.
- `floating_point_out`  out  32  registered binary32 result.
- `flags`  out  5  registered exception flags: [4] NV invalid, [3] DZ (always 0), [2] OF overflow, [1] UF underflow, [0] NX inexact.

## Operation
- **Unpack**
  - sign, 8-bit exponent, 23-bit fraction, hidden 1 for normal numbers.
  - Subnormal inputs (exp = 0, frac ≠ 0) are flushed to signed zero before use. No flag is raised for this.
- **Add/sub**
  - Sub inverts the sign of B, then follows the add path.
  - Align the smaller operand by right shift, keeping guard, round and sticky bits. Add or subtract magnitudes, then normalize: one right shift on carry, leading-zero left shift on cancellation.
  - An exact zero sum is +0, except in RDN where it is −0.
  - (+0)+(+0) = +0; (−0)+(−0) = −0.
- **Mul**
  - Sign = XOR of the operand signs.
  - 24×24 significand product; exponent = eA + eB − 127; normalize by at most 1 bit; keep guard and sticky bits.
- **Rounding** (all ops), applied to the normalized 24-bit significand plus G/R/S:
  - RNE: ties to even.
  - RTZ: truncate.
  - RDN: toward −∞.
  - RUP: toward +∞.
  - RMM: ties away from zero.
  - If rounding carries out, renormalize and increment the exponent.
  - NX is set when any discarded bit is nonzero.
- **Overflow** (rounded exponent ≥ 255): set OF|NX.
  - Result is ±inf for RNE and RMM, and for RDN on negative / RUP on positive results.
  - Otherwise result is ±0x7F7FFFFF (max finite).
- **Underflow** (result exponent < 1 after normalization, nonzero): result is signed zero; set UF|NX. No subnormal outputs are produced.
- **Special operands**
  - Any NaN input gives canonical NaN 0x7FC00000. NV is set only if an input is signaling (exp = 255, frac[22] = 0, frac ≠ 0).
  - inf − inf (effective) and 0 × inf give 0x7FC00000 with NV.
  - inf ± finite gives inf with the corresponding sign. inf × nonzero gives inf with the XOR sign. No flags are raised in these cases.
- Flags reflect only the operation whose result is currently on `floating_point_out`.

## Timing
- **Reset:** while `nrst` = 1, `floating_point_out` = 0x00000000, `flags` = 5'b00000, and all stage registers are cleared, regardless of the clock. Reset mid-operation discards all in-flight operations.
- **Pipeline:** operands, `frm` and `funct7` are captured on rising edge 1.
  - Stage 2 performs alignment / multiply.
  - Stage 3 performs normalize / round.
  - Result and flags appear on the outputs after rising edge 3 (latency 3 cycles) and remain valid until the next edge.
- **Throughput:** one operation per cycle, no stalls, no handshake. Each cycle's inputs form an independent operation; holding inputs constant yields a constant output from the third edge on.
- After reset deasserts, the outputs show 0 until the first captured operation reaches stage 3.

## Test plan
- Add: A = 0x3F800000, B = 0x3F800000, funct7 = 0000000, frm = 000 → after 3 edges, out = 0x40000000, flags = 00000.
- Sub and mul:
  - A = 0x40400000, B = 0x3F800000, funct7 = 0000100 → out = 0x40000000.
  - A = 0x40000000, B = 0x40400000, funct7 = 0001000 → out = 0x40C00000.
  - flags = 00000 in both cases.
- Rounding: A = 0x3F800000, B = 0x33800000, add.
  - frm = 000 → out = 0x3F800000, flags = 00001.
  - frm = 011 → out = 0x3F800001, flags = 00001.
- Overflow: A = 0x7F000000, B = 0x40000000, mul.
  - frm = 000 → out = 0x7F800000, flags = 00101.
  - frm = 001 → out = 0x7F7FFFFF, flags = 00101.
- Specials:
  - A = 0x7F800000, B = 0x7F800000, sub → out = 0x7FC00000, flags = 10000.
  - A = 0x3F800000, B = 0x3F800000, sub → out = 0x00000000 (0x80000000 when frm = 010).
- Pipelining and reset:
  - Apply 1+1, 2×3 and 3−1 on consecutive cycles → outputs 0x40000000, 0x40C00000 and 0x40000000 on consecutive cycles starting at edge 3.
  - Assert `nrst` mid-stream → outputs go to 0 immediately and stay 0 until 3 edges after deassertion.
